// File: rtl/lsu.sv
// Load/store unit: turns an ALU effective address into one req/ack
// data-memory transaction. It handles byte-lane steering, byte enables,
// load extension and timeout. Completion is a one-cycle done pulse.
module lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE, REQ, FIN} state_t;

    // Last counter value before giving up on the bus
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        misalign_q, misalign_d, timeout_q, timeout_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  size_q, size_d, off_q, off_d;
    logic        sext_q, sext_d;

    logic        addr_err;
    logic [3:0]  be_new;
    logic [31:0] wd_new;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_ext;

    // Alignment check, byte enables and replicated store data for a new request
    always_comb begin
        addr_err = 1'b0;
        be_new   = 4'b1111;
        wd_new   = wdata;
        case (size)
            2'b00: begin
                be_new = 4'b0001 << addr[1:0];
                wd_new = {4{wdata[7:0]}};
            end
            2'b01: begin
                addr_err = addr[0];
                be_new   = addr[1] ? 4'b1100 : 4'b0011;
                wd_new   = {2{wdata[15:0]}};
            end
            2'b10:   addr_err = (addr[1:0] != 2'b00);
            default: addr_err = 1'b1;
        endcase
    end

    // Pick the addressed lane(s) of the read word and extend to 32 bits
    always_comb begin
        case (off_q)
            2'd0:    lane_b = mem_rdata[7:0];
            2'd1:    lane_b = mem_rdata[15:8];
            2'd2:    lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   ld_ext = {{24{sext_q & lane_b[7]}}, lane_b};
            2'b01:   ld_ext = {{16{sext_q & lane_h[15]}}, lane_h};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        misalign_d  = misalign_q;
        timeout_d   = timeout_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        off_d       = off_q;
        sext_d      = sext_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    size_d = size;
                    off_d  = addr[1:0];
                    sext_d = sign_ext;
                    busy_d = 1'b1;
                    if (addr_err) begin
                        // No bus cycle: report the error straight away
                        state_d    = FIN;
                        misalign_d = 1'b1;
                        done_d     = 1'b1;
                    end else begin
                        state_d     = REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = be_new;
                        mem_wdata_d = wd_new;
                        cnt_d       = 16'd0;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d   = FIN;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    if (!mem_we_q) rdata_d = ld_ext;
                end else if (cnt_q == TMO_LAST) begin
                    state_d   = FIN;
                    mem_req_d = 1'b0;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                // Flags are only meaningful alongside done
                state_d    = IDLE;
                busy_d     = 1'b0;
                misalign_d = 1'b0;
                timeout_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            size_q      <= '0;
            off_q       <= '0;
            sext_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            misalign_q  <= misalign_d;
            timeout_q   <= timeout_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            off_q       <= off_d;
            sext_q      <= sext_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign misalign  = misalign_q;
    assign timeout   = timeout_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: each start pushes its expected outcome,
// the done monitor pops and compares.
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, is_store = 1'b0, sign_ext = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        busy, done, misalign, timeout, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .misalign(misalign), .timeout(timeout), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mis, tmo, we;
        logic [31:0] rd, addr, wd;
        logic [3:0]  be;
        int          lat, reqc, scyc;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   n_tests = 0, n_fail = 0;
    int   cyc = 0, ndone = 0, req_n = 0;
    int   ack_wait = 0, wcnt = 0;
    logic stray = 1'b0;
    logic [31:0] bus_rd = '0;
    logic [31:0] cap_addr, cap_wd;
    logic [3:0]  cap_be;
    logic        cap_we;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus responder: ack after ack_wait wait cycles (-1 = never)
    always @(negedge clk) begin
        if (mem_req && !mem_ack) begin
            if (wcnt == ack_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = bus_rd;
            end else wcnt++;
        end else begin
            mem_ack = stray;
            wcnt    = 0;
        end
    end

    // Done monitor: capture the bus request, compare on done
    always @(negedge clk) begin
        if (!rst_n) req_n = 0;
        else begin
            if (mem_req) begin
                if (req_n == 0) begin
                    cap_addr = mem_addr; cap_be = mem_be; cap_wd = mem_wdata; cap_we = mem_we;
                end
                req_n++;
            end
            if (q.size() > 0 && cyc == q[0].scyc + 1) chk("busy_c1", 32'(busy), 32'd1);
            if (done) begin
                if (q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
                else begin
                    me = q.pop_front();
                    chk("latency", 32'(cyc - me.scyc), 32'(me.lat));
                    chk("req_cycles", 32'(req_n), 32'(me.reqc));
                    chk("misalign", 32'(misalign), 32'(me.mis));
                    chk("timeout", 32'(timeout), 32'(me.tmo));
                    chk("rdata", rdata, me.rd);
                    chk("busy_done", 32'(busy), 32'd1);
                    if (me.reqc > 0) begin
                        chk("mem_addr", cap_addr, me.addr);
                        chk("mem_be", 32'(cap_be), 32'(me.be));
                        chk("mem_wdata", cap_wd, me.wd);
                        chk("mem_we", 32'(cap_we), 32'(me.we));
                    end
                end
                req_n = 0;
                ndone++;
            end
        end
    end

    task automatic issue(input logic st, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int w, input bit hold,
                         input logic e_mis, input logic e_tmo, input logic [31:0] e_rd,
                         input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic [31:0] e_wd, input int e_lat, input int e_reqc);
        exp_t e;
        int   n0;
        @(negedge clk);
        is_store = st; size = sz; sign_ext = sx; addr = a; wdata = wd;
        bus_rd = rd; ack_wait = w; start = 1'b1;
        e.mis = e_mis; e.tmo = e_tmo; e.we = st; e.rd = e_rd; e.addr = e_addr;
        e.be = e_be; e.wd = e_wd; e.lat = e_lat; e.reqc = e_reqc; e.scyc = cyc;
        q.push_back(e);
        n0 = ndone;
        @(negedge clk); #1;
        if (!hold) start = 1'b0;
        for (int i = 0; i < 40 && ndone == n0; i++) begin
            @(negedge clk); #1;
        end
        start = 1'b0;
        if (ndone == n0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        rst_n = 1'b1;

        // word load, 2 wait states
        issue(0, 2'b10, 0, 32'h100, 0, 32'hDEADBEEF, 2, 0, 0, 0, 32'hDEADBEEF, 32'h100, 4'hF, 0, 4, 3);
        // byte loads, signed / unsigned, lane 3
        issue(0, 2'b00, 1, 32'h103, 0, 32'h80FF1234, 0, 0, 0, 0, 32'hFFFFFF80, 32'h100, 4'h8, 0, 2, 1);
        issue(0, 2'b00, 0, 32'h103, 0, 32'h80FF1234, 0, 0, 0, 0, 32'h00000080, 32'h100, 4'h8, 0, 2, 1);
        issue(0, 2'b00, 0, 32'h101, 0, 32'h80FF1234, 1, 0, 0, 0, 32'h00000012, 32'h100, 4'h2, 0, 3, 2);
        // half loads
        issue(0, 2'b01, 1, 32'h100, 0, 32'h0000F00D, 0, 0, 0, 0, 32'hFFFFF00D, 32'h100, 4'h3, 0, 2, 1);
        issue(0, 2'b01, 1, 32'h102, 0, 32'h80FF1234, 0, 0, 0, 0, 32'hFFFF80FF, 32'h100, 4'hC, 0, 2, 1);
        // stores leave rdata alone
        issue(1, 2'b00, 0, 32'h201, 32'h000000AB, 32'h55555555, 1, 0, 0, 0, 32'hFFFF80FF, 32'h200, 4'h2, 32'hABABABAB, 3, 2);
        issue(1, 2'b01, 0, 32'h202, 32'h00001234, 32'h55555555, 0, 0, 0, 0, 32'hFFFF80FF, 32'h200, 4'hC, 32'h12341234, 2, 1);
        issue(1, 2'b10, 0, 32'h20C, 32'hCAFEF00D, 32'h55555555, 0, 0, 0, 0, 32'hFFFF80FF, 32'h20C, 4'hF, 32'hCAFEF00D, 2, 1);
        // misaligned / illegal size: no bus cycle, done one cycle after start
        issue(0, 2'b10, 0, 32'h102, 0, 0, 0, 0, 1, 0, 32'hFFFF80FF, 0, 0, 0, 1, 0);
        issue(0, 2'b01, 0, 32'h101, 0, 0, 0, 0, 1, 0, 32'hFFFF80FF, 0, 0, 0, 1, 0);
        issue(1, 2'b11, 0, 32'h100, 0, 0, 0, 0, 1, 0, 32'hFFFF80FF, 0, 0, 0, 1, 0);
        // no ack: mem_req high exactly TIMEOUT cycles
        issue(0, 2'b00, 1, 32'h104, 0, 0, -1, 0, 0, 1, 32'hFFFF80FF, 32'h104, 4'h1, 0, 5, 4);
        // start held high through the whole transfer, including the done cycle
        issue(0, 2'b10, 0, 32'h108, 0, 32'h12345678, 1, 1, 0, 0, 32'h12345678, 32'h108, 4'hF, 0, 3, 2);

        // stray ack while idle must not start anything
        @(negedge clk); stray = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("stray_req", 32'(mem_req), 32'd0);
        chk("stray_busy", 32'(busy), 32'd0);
        stray = 1'b0;
        repeat (2) @(negedge clk);

        // reset during REQ abandons the transfer silently
        is_store = 1'b0; size = 2'b10; addr = 32'h300; ack_wait = -1; start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        @(negedge clk); #1 chk("pre_rst_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(0, 2'b10, 0, 32'h304, 0, 32'hA5A5A5A5, 0, 0, 0, 0, 32'hA5A5A5A5, 32'h304, 4'hF, 0, 2, 1);

        repeat (4) @(negedge clk);
        chk("pending", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got hang want finish");
        $fatal(1);
    end
endmodule
